seq_enable_bank: RTL and testbench

SEQ_ENABLE_BANK -- requirements
Module: seq_enable_bank

---
 rtl/seq_enable_bank.sv | 75 +++++++
 tb/tb_seq_enable_bank.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_enable_bank.sv
// rtl/seq_enable_bank.sv - bank of independent enable-gated pipelines with fill tracking and load counters
module seq_enable_bank #(
    parameter int               WIDTH       = 8,
    parameter int               CHANNELS    = 4,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic [CHANNELS-1:0]         en,
    input  logic [CHANNELS*WIDTH-1:0]   d,
    output logic [CHANNELS*WIDTH-1:0]   q,
    output logic [CHANNELS-1:0]         valid,
    output logic [CHANNELS*CNT_W-1:0]   load_cnt,
    output logic                        any_en
);

    // fill must be able to represent the value STAGES itself
    localparam int FILL_W = $clog2(STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(STAGES);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(STAGES - 1);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0]  pipe [STAGES];
        logic [FILL_W-1:0] fill;
        logic [CNT_W-1:0]  cnt;
        logic              vld;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < STAGES; k++) begin
                    pipe[k] <= RESET_VALUE;
                end
                fill <= '0;
                cnt  <= '0;
                vld  <= 1'b0;
            end else if (clr) begin
                for (int k = 0; k < STAGES; k++) begin
                    pipe[k] <= RESET_VALUE;
                end
                fill <= '0;
                cnt  <= '0;
                vld  <= 1'b0;
            end else if (en[c]) begin
                pipe[0] <= d[c*WIDTH +: WIDTH];
                for (int k = 1; k < STAGES; k++) begin
                    pipe[k] <= pipe[k-1];
                end
                if (fill != FILL_FULL) begin
                    fill <= fill + FILL_W'(1);
                end
                if (cnt != '1) begin
                    cnt <= cnt + CNT_W'(1);
                end
                // valid is registered, so look one load ahead of fill
                vld <= (fill >= FILL_LAST);
            end
        end

        assign q[c*WIDTH +: WIDTH]        = pipe[STAGES-1];
        assign load_cnt[c*CNT_W +: CNT_W] = cnt;
        assign valid[c]                   = vld;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_en <= 1'b0;
        end else begin
            any_en <= |en;
        end
    end

endmodule

// File: tb/tb_seq_enable_bank.sv
// tb/tb_seq_enable_bank.sv - table, corner-case and randomized checks of seq_enable_bank
module tb_seq_enable_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  en  = '0;
    logic [31:0] d   = '0;
    logic [31:0] q;
    logic [3:0]  valid;
    logic [15:0] load_cnt;
    logic        any_en;

    int vectors = 0;
    int miscompares = 0;

    seq_enable_bank #(
        .WIDTH(8), .CHANNELS(4), .STAGES(2), .RESET_VALUE(8'h00), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .d(d),
        .q(q), .valid(valid), .load_cnt(load_cnt), .any_en(any_en)
    );

    always #5 clk = ~clk;

    // reference: full history of loads per channel since last reset/clear
    logic [7:0] hist [4][$];
    logic       m_any;

    task automatic model_reset();
        for (int c = 0; c < 4; c++) hist[c].delete();
        m_any = 1'b0;
    endtask

    task automatic model_edge();
        if (rst) return;
        if (clr) begin
            for (int c = 0; c < 4; c++) hist[c].delete();
        end else begin
            for (int c = 0; c < 4; c++)
                if (en[c]) hist[c].push_back(d[c*8 +: 8]);
        end
        m_any = |en;
    endtask

    task automatic compare(input string name, input logic [31:0] eq, input logic [3:0] ev,
                           input logic [15:0] ec, input logic ea);
        vectors++;
        if (q !== eq || valid !== ev || load_cnt !== ec || any_en !== ea) begin
            miscompares++;
            $display("FAIL %s: got q=%h valid=%b cnt=%h any=%b, want q=%h valid=%b cnt=%h any=%b",
                     name, q, valid, load_cnt, any_en, eq, ev, ec, ea);
        end
    endtask

    task automatic check_model(input string name);
        logic [31:0] eq;
        logic [3:0]  ev;
        logic [15:0] ec;
        int n;
        for (int c = 0; c < 4; c++) begin
            n = hist[c].size();
            eq[c*8 +: 8] = (n >= 2) ? hist[c][n-2] : 8'h00;
            ev[c]        = (n >= 2);
            ec[c*4 +: 4] = (n > 15) ? 4'hF : 4'(n);
        end
        compare(name, eq, ev, ec, m_any);
    endtask

    // called at posedge+1; applies inputs, lets one edge pass, returns at posedge+1
    task automatic step(input logic c_clr, input logic [3:0] c_en, input logic [31:0] c_d);
        clr = c_clr;
        en  = c_en;
        d   = c_d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic        clr;
        logic [3:0]  en;
        logic [31:0] d;
        logic [31:0] eq;
        logic [3:0]  ev;
        logic [15:0] ec;
        logic        ea;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b0, 4'b0001, 32'h0000_00A5, 32'h0000_0000, 4'b0000, 16'h0001, 1'b1};
        tbl[1] = '{1'b0, 4'b0001, 32'h0000_003C, 32'h0000_00A5, 4'b0001, 16'h0002, 1'b1};
        tbl[2] = '{1'b0, 4'b0010, 32'h0000_1100, 32'h0000_00A5, 4'b0001, 16'h0012, 1'b1};
        tbl[3] = '{1'b0, 4'b0000, 32'hFFFF_FFFF, 32'h0000_00A5, 4'b0001, 16'h0012, 1'b0};
        tbl[4] = '{1'b0, 4'b0000, 32'h1234_5678, 32'h0000_00A5, 4'b0001, 16'h0012, 1'b0};
        tbl[5] = '{1'b0, 4'b0000, 32'hFFFF_FFFF, 32'h0000_00A5, 4'b0001, 16'h0012, 1'b0};
        tbl[6] = '{1'b0, 4'b0010, 32'h0000_2200, 32'h0000_11A5, 4'b0011, 16'h0022, 1'b1};
        tbl[7] = '{1'b1, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0000, 16'h0000, 1'b1};
        tbl[8] = '{1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 16'h0000, 1'b0};

        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare("reset_state", 32'h0, 4'h0, 16'h0, 1'b0);

        // asynchronous reset between edges, then edges while held in reset
        step(1'b0, 4'b1001, 32'h5A00_00C3);
        step(1'b0, 4'b1001, 32'h6B00_00D4);
        compare("pre_reset_load", 32'h5A00_00C3, 4'b1001, 16'h2002, 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare("async_reset", 32'h0, 4'h0, 16'h0, 1'b0);
        en = 4'hF;
        d  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        compare("reset_hold", 32'h0, 4'h0, 16'h0, 1'b0);
        rst = 1'b0;
        en  = 4'h0;

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].clr, tbl[i].en, tbl[i].d);
            compare($sformatf("table_%0d", i), tbl[i].eq, tbl[i].ev, tbl[i].ec, tbl[i].ea);
        end

        // partial fill discarded by a reset pulse
        step(1'b0, 4'b1000, 32'h7700_0000);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        rst = 1'b0;
        step(1'b0, 4'b1000, 32'h8800_0000);
        compare("refill_1", 32'h0, 4'b0000, 16'h1000, 1'b1);
        step(1'b0, 4'b1000, 32'h9900_0000);
        compare("refill_2", 32'h8800_0000, 4'b1000, 16'h2000, 1'b1);

        // load counter saturation on ch2 while data keeps shifting
        step(1'b1, 4'b0000, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 4'b0100, {8'h00, 8'(i), 16'h0000});
        end
        compare("saturate_20", 32'h0013_0000, 4'b0100, 16'h0F00, 1'b1);
        step(1'b0, 4'b0100, 32'h0015_0000);
        compare("saturate_21", 32'h0014_0000, 4'b0100, 16'h0F00, 1'b1);
        check_model("model_sync");

        // randomized against the reference model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst = 1'b1;
                model_reset();
                #1;
                check_model("rand_async_rst");
                rst = 1'b0;
            end
            step($urandom_range(0, 31) == 0, 4'($urandom_range(0, 15)), $urandom);
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
